// File: rtl/lifo_stack_param.sv
// -----------------------------------------------------------------------------
// lifo_stack_param
//
// Parametrised synchronous LIFO operand stack. The top-of-stack value is held
// in its own register, so dout is a clean flop output and never a read through
// the storage array. Each rising edge decodes exactly one operation, in this
// priority order: flush, replace (push+pop on a non-empty stack), push,
// refused push, pop, pop-to-empty, refused pop, idle. Any accepted operation
// raises ack for exactly one cycle. Refused operations set sticky error flags
// and leave the stack unchanged.
//
// Parameters
//   DATA_W  word width in bits (>= 1)
//   DEPTH   number of entries; a power of two, >= 2
//   CNT_W   occupancy count width (derived; holds 0..DEPTH)
//
// Ports
//   clk      system clock; all state updates on the rising edge
//   rst_n    asynchronous active-low reset
//   push     push request
//   pop      pop request
//   flush    synchronous clear of contents and error flags; highest priority
//   err_clr  synchronous clear of the sticky error flags
//   din      word to push, or the new top on a replace
//   dout     registered top-of-stack value; 0 when the stack is empty
//   count    registered number of valid entries
//   empty    count == 0
//   full     count == DEPTH
//   ack      one-cycle pulse after an accepted push/pop/replace/flush
//   ovf_err  sticky: a push was refused because the stack was full
//   unf_err  sticky: a pop was refused because the stack was empty
// -----------------------------------------------------------------------------
module lifo_stack_param #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ack,
  output logic              ovf_err,
  output logic              unf_err
);

  // Index width into the storage array. DEPTH is a power of two, so
  // CNT_W == IDX_W + 1 and the count can hold the value DEPTH.
  localparam int IDX_W = $clog2(DEPTH);

  // One value per decoded operation; the datapath below keys off this alone.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_REPLACE,
    OP_PUSH,
    OP_OVF,
    OP_POP,
    OP_POP_LAST,
    OP_UNF
  } op_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_dout;
  logic              r_ack;
  logic              r_ovf_err;
  logic              r_unf_err;

  // ---------------------------------------------------------------------------
  // Combinational decode and next-state
  // ---------------------------------------------------------------------------
  op_e               w_op;
  logic              w_empty;
  logic              w_full;
  logic [IDX_W-1:0]  w_wr_idx;     // slot above the top (push target)
  logic [IDX_W-1:0]  w_top_idx;    // current top (replace target)
  logic [IDX_W-1:0]  w_below_idx;  // entry that becomes the top after a pop
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_waddr;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_dout_nxt;
  logic              w_ack_nxt;
  logic              w_ovf_nxt;
  logic              w_unf_nxt;

  // Flags are decoded from the registered count only, so no input reaches an
  // output combinationally.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // Truncation is intended: the write index is only used when count < DEPTH,
  // and the top/below indices only when count is at least 1/2 respectively.
  assign w_wr_idx    = IDX_W'(r_count);
  assign w_top_idx   = IDX_W'(r_count - CNT_W'(1));
  assign w_below_idx = IDX_W'(r_count - CNT_W'(2));

  // Operation decode in priority order. push+pop on an empty stack falls
  // through to a plain push; push+pop on a full stack is a replace, so it
  // never raises an overflow.
  always_comb begin
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    w_op = OP_IDLE;
    if (flush) begin
      w_op = OP_FLUSH;
    end else if (push && pop && !w_empty) begin
      w_op = OP_REPLACE;
    end else if (push && !w_full) begin
      w_op = OP_PUSH;
    end else if (push) begin
      w_op = OP_OVF;
    end else if (pop && (r_count > CNT_W'(1))) begin
      w_op = OP_POP;
    end else if (pop && !w_empty) begin
      w_op = OP_POP_LAST;
    end else if (pop) begin
      w_op = OP_UNF;
    end
  end

  // Datapath next-state driven by the decoded operation.
  always_comb begin
    w_count_nxt = r_count;
    w_dout_nxt  = r_dout;
    w_ack_nxt   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_waddr = w_wr_idx;

    unique case (w_op)
      OP_FLUSH: begin
        w_count_nxt = '0;
        w_dout_nxt  = '0;
        w_ack_nxt   = 1'b1;
      end
      OP_REPLACE: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = w_top_idx;
        w_dout_nxt  = din;
        w_ack_nxt   = 1'b1;
      end
      OP_PUSH: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = w_wr_idx;
        w_count_nxt = r_count + CNT_W'(1);
        w_dout_nxt  = din;
        w_ack_nxt   = 1'b1;
      end
      OP_POP: begin
        w_count_nxt = r_count - CNT_W'(1);
        w_dout_nxt  = r_mem[w_below_idx];
        w_ack_nxt   = 1'b1;
      end
      OP_POP_LAST: begin
        w_count_nxt = '0;
        w_dout_nxt  = '0;
        w_ack_nxt   = 1'b1;
      end
      OP_OVF, OP_UNF, OP_IDLE: begin
        // State held; the defaults already cover it.
      end
      default: begin
      end
    endcase
  end

  // Sticky error flags. Flush clears unconditionally. Otherwise err_clr
  // clears, but a refusal in the same cycle wins and sets the flag.
  always_comb begin
    w_ovf_nxt = r_ovf_err;
    w_unf_nxt = r_unf_err;
    if (flush) begin
      w_ovf_nxt = 1'b0;
      w_unf_nxt = 1'b0;
    end else begin
      if (err_clr) begin
        w_ovf_nxt = 1'b0;
        w_unf_nxt = 1'b0;
      end
      if (w_op == OP_OVF) w_ovf_nxt = 1'b1;
      if (w_op == OP_UNF) w_unf_nxt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_count   <= '0;
      r_dout    <= '0;
      r_ack     <= 1'b0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_dout    <= w_dout_nxt;
      r_ack     <= w_ack_nxt;
      r_ovf_err <= w_ovf_nxt;
      r_unf_err <= w_unf_nxt;
    end
  end

  // NOTE: the storage array is deliberately left out of reset. Its contents
  // are unreachable while count == 0, and a reset-free array maps onto plain
  // register files or RAM macros.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= din;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout    = r_dout;
  assign count   = r_count;
  assign empty   = w_empty;
  assign full    = w_full;
  assign ack     = r_ack;
  assign ovf_err = r_ovf_err;
  assign unf_err = r_unf_err;

endmodule

// File: doc/lifo_stack_param.md
Name: lifo_stack_param

Overview:
Parametrised synchronous LIFO stack with registered top-of-stack output, occupancy count, full/empty flags, sticky overflow/underflow error flags and a one-cycle acknowledge pulse per accepted operation. It is the generalised successor to the fixed 8-bit x 16-entry stack. It adds configurable data width and depth, simultaneous push+pop (replace-top) and synchronous flush. It sits between the pin-level I/O wrapper and core logic as a general-purpose operand stack.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
CNT_W, $clog2(DEPTH+1), derived local parameter: width of occupancy count (holds 0..DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
push  input  1  push request, sampled on rising clk
pop  input  1  pop request, sampled on rising clk
flush  input  1  synchronous clear of stack contents and error flags; highest priority
err_clr  input  1  synchronous clear of sticky error flags
din  input  DATA_W  data to push
dout  output  DATA_W  registered top-of-stack value; 0 when empty
count  output  CNT_W  registered number of valid entries
empty  output  1  count == 0
full  output  1  count == DEPTH
ack  output  1  one-cycle pulse, cycle after an accepted push/pop/replace/flush
ovf_err  output  1  sticky: push refused because stack full
unf_err  output  1  sticky: pop refused because stack empty

Behaviour:
- Clock: one clock, clk. Reset: rst_n, asynchronous, active-low. Assertion immediately forces count=0, dout=0, empty=1, full=0, ack=0, ovf_err=0, unf_err=0. Memory array is not reset; its contents are unobservable while count=0.
- Reset released mid-operation: the first rising edge after deassertion processes inputs normally from the empty state.
- Storage: DEPTH x DATA_W register array; write index = count; top index = count-1.
- Operation decode per rising edge, in priority order:
  1. flush=1: count<=0, dout<=0, ovf_err<=0, unf_err<=0, ack<=1. push/pop/err_clr ignored.
  2. push=1, pop=1, count>0 (REPLACE): mem[count-1]<=din, dout<=din, count unchanged, ack<=1. Also legal when full; no error raised.
  3. push=1, pop=1, count=0: treated as plain PUSH; no unf_err.
  4. push=1, pop=0, count<DEPTH (PUSH): mem[count]<=din, dout<=din, count<=count+1, ack<=1.
  5. push=1, pop=0, count=DEPTH: no state change, ovf_err<=1, ack<=0.
  6. pop=1, push=0, count>1 (POP): dout<=mem[count-2], count<=count-1, ack<=1.
  7. pop=1, push=0, count=1 (POP to empty): dout<=0, count<=0, ack<=1.
  8. pop=1, push=0, count=0: no state change, unf_err<=1, ack<=0.
  9. Otherwise idle: ack<=0, all state held.
- err_clr (when flush=0) clears ovf_err/unf_err. If a new error event occurs in the same cycle, set wins.
- Latency: dout, count, empty, full and ack reflect an operation exactly one cycle after the sampling edge. Back-to-back operations every cycle are supported with no bubbles.
- full/empty are decoded from the registered count; no combinational path from inputs to any output.
- count never exceeds DEPTH and never wraps below 0. Refused operations leave memory untouched.

Test Plan:
- Reset then fill: DATA_W=8, DEPTH=16; push 0x01..0x10 on 16 consecutive cycles -> count=16, full=1, dout=0x10, ack high each cycle after. 17th push 0xAA -> ovf_err=1, ack=0, dout stays 0x10.
- Drain: from full, pop 16 consecutive cycles -> dout sequence 0x0F..0x01 then 0x00, empty=1. Extra pop -> unf_err=1, count stays 0.
- Replace: push 0x11, 0x22; then push+pop with din=0x99 -> dout=0x99, count=2. Pop -> dout=0x11.
- Push+pop on empty stack with din=0x5A -> count=1, dout=0x5A, unf_err=0. Push+pop with full stack -> no ovf_err, count=16.
- Errors and flush: set both errors, then err_clr together with a refused pop -> unf_err=1, ovf_err=0. Flush with count=7 -> count=0, dout=0, errors 0, ack=1.
- Async reset mid-fill: assert rst_n low between clock edges with count=5 -> outputs reset immediately. After release, a push of 0x3C -> count=1, dout=0x3C. Repeat with DATA_W=12, DEPTH=4 for overflow at count=4.
